// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bank
// Description : Multi-channel pushbutton/switch debouncer. A shared
//               programmable prescaler produces a one-cycle tick every
//               TICK_DIV enabled cycles. Each channel has a two-flop
//               synchroniser followed by a confirm counter that accepts a new
//               level only after it has persisted for STABLE_TICKS ticks.
//               Each channel reports a clean level plus rise/fall pulses.
// Ports       : clk        - system clock, all state on rising edge
//               rst_a_p    - synchronous active-high reset
//               en         - 1 = prescaler and confirm counters run, 0 = freeze
//               btn_in     - raw asynchronous inputs, one per channel
//               btn_level  - debounced, normalised level per channel
//               btn_rise   - one-cycle pulse on accepted 0->1
//               btn_fall   - one-cycle pulse on accepted 1->0
//               tick       - one-cycle prescaler strobe
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bank #(
    parameter int CHANNELS     = 4,
    parameter int TICK_DIV     = 5000,
    parameter int STABLE_TICKS = 4,
    parameter bit ACTIVE_LOW   = 1'b0,
    parameter bit INIT_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst_a_p,
    input  logic                en,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_rise,
    output logic [CHANNELS-1:0] btn_fall,
    output logic                tick
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    // cnt+1 == STABLE_TICKS is the acceptance condition, i.e. cnt == STABLE_TICKS-1
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    // ------------------------------------------------------------------------
    // Input normalisation and two-flop synchroniser (runs regardless of en)
    // ------------------------------------------------------------------------
    logic [CHANNELS-1:0] raw_w;
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;

    assign raw_w = btn_in ^ {CHANNELS{ACTIVE_LOW}};

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            sync1_q <= {CHANNELS{INIT_LEVEL}};
            sync2_q <= {CHANNELS{INIT_LEVEL}};
        end else begin
            sync1_q <= raw_w;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Shared prescaler. The tick is registered so it appears in the cycle
    // after the wrap edge; with en low both phase and tick are frozen/zero.
    // ------------------------------------------------------------------------
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             tick_q;
    logic             tick_d;

    always_comb begin
        pre_d  = pre_q;
        tick_d = 1'b0;
        if (en) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                tick_d = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

    // ------------------------------------------------------------------------
    // Per-channel confirm counter, level and edge pulses
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;
        logic             rise_q;
        logic             rise_d;
        logic             fall_q;
        logic             fall_d;

        always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (tick_q) begin
                if (sync2_q[i] == level_q) begin
                    // Input agrees with accepted level: any partial progress
                    // was a bounce, so start over.
                    cnt_d = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    level_d = sync2_q[i];
                    cnt_d   = '0;
                    rise_d  = sync2_q[i];
                    fall_d  = ~sync2_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst_a_p) begin
                cnt_q   <= '0;
                level_q <= INIT_LEVEL;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign btn_level[i] = level_q;
        assign btn_rise[i]  = rise_q;
        assign btn_fall[i]  = fall_q;
    end

endmodule
`default_nettype wire
